// File: rtl/if_prefetch_pkg.sv
// rtl/if_prefetch_pkg.sv - shared widths, constants and anomaly rule for the fetch stage
package if_prefetch_pkg;

    localparam int          INST_WIDTH       = 32;
    localparam int          SYS_ADDR_SPACE   = 32;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Only 32-bit encodings at word-aligned addresses that fetched cleanly are trusted.
    function automatic logic is_anomaly(input logic [1:0] inst_lo,
                                        input logic [1:0] pc_lo,
                                        input logic       bus_err);
        return (inst_lo != 2'b11) || (pc_lo != 2'b00) || bus_err;
    endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// rtl/if_prefetch_if.sv - request/response instruction memory port
interface if_prefetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [INST_W-1:0] mem_rdata;
    logic              mem_err;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err
    );
endinterface

// File: rtl/if_prefetch_fetch_fifo.sv
// rtl/if_prefetch_fetch_fifo.sv - synchronous FIFO with flush, occupancy count and registered head
module if_prefetch_fetch_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction fetch stage with in-order prefetch queue and redirect flush
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int                ADDR_W          = SYS_ADDR_SPACE,
    parameter int                INST_W          = INST_WIDTH,
    parameter int                DEPTH           = 4,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               pc_we_i,
    input  logic [ADDR_W-1:0]  pc_i,
    if_prefetch_if.master      mem,
    output logic               valid_o,
    output logic [INST_W-1:0]  inst_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               anomaly_o
);
    localparam int OW      = $clog2(MAX_OUTSTANDING + 1);
    localparam int QCW     = $clog2(DEPTH + 1);
    localparam int ENTRY_W = ADDR_W + INST_W + 1;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [OW-1:0]      drop_cnt;
    logic [OW-1:0]      outstanding;
    logic               a_full;
    logic               a_empty;
    logic [ADDR_W-1:0]  a_head;

    logic               q_full;
    logic               q_empty;
    logic [QCW-1:0]     q_count;
    logic [ENTRY_W-1:0] q_head;
    logic [ADDR_W-1:0]  head_pc;
    logic [INST_W-1:0]  head_inst;
    logic               head_err;

    logic               grant;
    logic               resp;
    logic               q_push;
    logic               q_pop;
    logic               credit_ok;

    // Credits count buffered entries plus responses that will still be kept.
    assign credit_ok = (32'(q_count) + 32'(outstanding) - 32'(drop_cnt)) < 32'(DEPTH);

    assign mem.mem_req  = !rst_i && !pc_we_i && !a_full && credit_ok;
    assign mem.mem_addr = fetch_pc;
    assign grant        = mem.mem_req && mem.mem_gnt;
    assign resp         = mem.mem_rvalid;

    assign q_push = resp && (drop_cnt == '0) && !pc_we_i;
    assign {head_pc, head_inst, head_err} = q_head;

    assign valid_o   = !q_empty && !pc_we_i;
    assign q_pop     = valid_o && !stall_i;
    assign inst_o    = q_empty ? INST_W'(INST_NOP) : head_inst;
    assign pc_o      = q_empty ? fetch_pc : head_pc;
    assign anomaly_o = valid_o && is_anomaly(head_inst[1:0], head_pc[1:0], head_err);

    // Address queue survives redirects: dropped responses still retire their entry.
    if_prefetch_fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_addr_q (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (grant),
        .push_data (fetch_pc),
        .pop       (resp),
        .flush     (1'b0),
        .full      (a_full),
        .empty     (a_empty),
        .count     (outstanding),
        .head      (a_head)
    );

    if_prefetch_fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (q_push),
        .push_data ({a_head, mem.mem_rdata, mem.mem_err}),
        .pop       (q_pop),
        .flush     (pc_we_i),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count),
        .head      (q_head)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else if (pc_we_i) begin
            fetch_pc <= pc_i;
            drop_cnt <= outstanding - OW'(resp);
        end else begin
            if (grant)                     fetch_pc <= fetch_pc + ADDR_W'(4);
            if (resp && (drop_cnt != '0))  drop_cnt <= drop_cnt - OW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(q_push && q_full));
            assert (!(resp && a_empty));
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - self-checking bench for if_prefetch against a fetch-stream reference model
module tb_if_prefetch;

    localparam int          MAX_OUT   = 2;
    localparam logic [31:0] RESET_PC  = 32'h0;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] ANOM_ADDR = 32'h8;
    localparam logic [31:0] ERR_ADDR  = 32'h20;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        pc_we_i = 1'b0;
    logic [31:0] pc_i = 32'h0;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        anomaly_o;

    always #5 clk = ~clk;

    if_prefetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

    if_prefetch #(
        .ADDR_W          (32),
        .INST_W          (32),
        .DEPTH           (4),
        .MAX_OUTSTANDING (MAX_OUT),
        .RESET_PC        (RESET_PC)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .stall_i   (stall_i),
        .pc_we_i   (pc_we_i),
        .pc_i      (pc_i),
        .mem       (bus),
        .valid_o   (valid_o),
        .inst_o    (inst_o),
        .pc_o      (pc_o),
        .anomaly_o (anomaly_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          idle = 0;
    int          lat = 1;
    logic        lat_rand = 1'b0;
    logic        rst = 1'b1, stall = 1'b0, pc_we = 1'b0, gnt = 1'b1;
    logic [31:0] pc_tgt = 32'h0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_fetch = RESET_PC;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_addr = 32'h0;
    logic        need_first = 1'b1;
    logic [31:0] first_pc = 32'hdead_beef;
    logic        first_anom = 1'b0;
    logic [31:0] err_inst = 32'h0;
    logic        err_anom = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == ANOM_ADDR) return 32'h0000_4501;
        return {a[23:0], 8'h13};
    endfunction

    function automatic logic exp_anom(input logic [31:0] inst, input logic [31:0] a);
        return (inst[1:0] != 2'b11) || (a[1:0] != 2'b00) || (a == ERR_ADDR);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        resp;
        logic [31:0] a;
        @(negedge clk);
        rst_i        = rst;
        stall_i      = stall;
        pc_we_i      = pc_we;
        pc_i         = pc_tgt;
        bus.mem_gnt  = gnt;
        resp         = !rst && (mq.size() > 0) && (mq[0].due <= cyc);
        a            = resp ? mq[0].addr : 32'h0;
        bus.mem_rvalid = resp;
        bus.mem_rdata  = resp ? mem_word(a) : $urandom;
        bus.mem_err    = resp ? (a == ERR_ADDR) : 1'($urandom);
        #1;
        if (!rst) begin
            if (valid_o) begin
                check("pc_o", pc_o, exp_pc);
                check("inst_o", inst_o, mem_word(exp_pc));
                check("anomaly_o", anomaly_o, exp_anom(mem_word(exp_pc), exp_pc));
                if (need_first) begin
                    first_pc   = pc_o;
                    first_anom = anomaly_o;
                    need_first = 1'b0;
                end
                if (pc_o == ERR_ADDR) begin
                    err_inst = inst_o;
                    err_anom = anomaly_o;
                end
            end else if (!pc_we) begin
                check("empty_inst", inst_o, NOP);
                check("empty_anom", anomaly_o, 1'b0);
                check("empty_pc", pc_o, exp_fetch);
            end
            if (pc_we) begin
                check("redirect_valid", valid_o, 1'b0);
                check("redirect_req", bus.mem_req, 1'b0);
            end
            if (mq.size() >= MAX_OUT) check("credit_req", bus.mem_req, 1'b0);
            if (hold_prev && !pc_we) begin
                check("req_hold", bus.mem_req, 1'b1);
                check("addr_hold", bus.mem_addr, hold_addr);
            end
            if (bus.mem_req && gnt) check("grant_addr", bus.mem_addr, exp_fetch);
            if (valid_o || pc_we) idle = 0; else idle++;
            check("progress", idle < 40, 1'b1);
        end
        if (rst) begin
            mq.delete();
            exp_pc     = RESET_PC;
            exp_fetch  = RESET_PC;
            hold_prev  = 1'b0;
            need_first = 1'b1;
            idle       = 0;
        end else begin
            hold_prev = bus.mem_req && !gnt;
            hold_addr = bus.mem_addr;
            if (resp) void'(mq.pop_front());
            if (pc_we) begin
                exp_pc     = pc_tgt;
                exp_fetch  = pc_tgt;
                need_first = 1'b1;
            end else begin
                if (bus.mem_req && gnt) begin
                    req_t r;
                    r.addr = exp_fetch;
                    r.due  = cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat);
                    mq.push_back(r);
                    exp_fetch += 32'd4;
                end
                if (valid_o && !stall) exp_pc += 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic redirect(input logic [31:0] tgt);
        pc_we  = 1'b1;
        pc_tgt = tgt;
        step();
        pc_we  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, valid_o, 1'b0);
        check({tag, "_req"}, bus.mem_req, 1'b0);
        check({tag, "_inst"}, inst_o, NOP);
        check({tag, "_pc"}, pc_o, RESET_PC);
        check({tag, "_anom"}, anomaly_o, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        bus.mem_err    = 1'b0;

        rst = 1'b1;
        run(2);
        check_reset_outputs("reset");

        // Reset release, 1-cycle memory: first valid on the third cycle, then stall 6 cycles.
        rst = 1'b0;
        stall = 1'b0;
        gnt = 1'b1;
        lat = 1;
        step();
        step();
        check("first_valid_early", valid_o, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("stall_valid", valid_o, 1'b1);
            check("stall_pc", pc_o, 32'h0);
        end
        check("full_req_drop", bus.mem_req, 1'b0);
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("no_bubble", valid_o, 1'b1);
            check("release_pc", pc_o, 32'(4 * i));
        end
        run(6);

        // Redirect with two slow fetches in flight.
        lat = 3;
        for (int i = 0; i < 30 && mq.size() < 2; i++) step();
        check("inflight_two", mq.size(), 2);
        redirect(32'h100);
        run(15);
        check("redirect_first_pc", first_pc, 32'h100);

        lat = 1;
        redirect(32'h102);
        run(8);
        check("misaligned_pc", first_pc, 32'h102);
        check("misaligned_anom", first_anom, 1'b1);

        redirect(32'hFFFF_FFF8);
        run(10);
        check("wrap_first_pc", first_pc, 32'hFFFF_FFF8);

        redirect(32'h18);
        run(12);
        check("err_inst", err_inst, mem_word(ERR_ADDR));
        check("err_anom", err_anom, 1'b1);

        // Reset mid-stream with a stalled, partly filled queue.
        stall = 1'b1;
        lat = 2;
        run(5);
        rst = 1'b1;
        step();
        step();
        check_reset_outputs("midreset");
        rst = 1'b0;
        stall = 1'b0;
        lat = 1;
        run(8);
        check("restart_pc", first_pc, RESET_PC);

        lat_rand = 1'b1;
        for (int i = 0; i < 600; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            gnt   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                pc_we  = 1'b1;
                pc_tgt = $urandom & 32'h0000_0FFF;
            end else begin
                pc_we  = 1'b0;
            end
            step();
        end
        pc_we = 1'b0;
        stall = 1'b0;
        gnt = 1'b1;
        run(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
Parametrised instruction-fetch stage that replaces the single-cycle combinational ROM fetch with a request/response memory port and an in-order prefetch queue.
- Keeps up to MAX_OUTSTANDING fetches in flight.
- Buffers up to DEPTH fetched instructions.
- Honours IF_ID stall by holding the queue head.
- Handles branch redirects by flushing the queue and discarding stale responses.
- Sits between the branch unit / hazard unit and the IF_ID register.

Parameters:
ADDR_W, 32, instruction address width (matches `SYS_ADDR_SPACE)
INST_W, 32, instruction width (matches `INST_WIDTH)
DEPTH, 4, prefetch queue entries; power of two, >= 2
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests; 1..DEPTH
RESET_PC, 32'h0, fetch address after reset

Ports:
clk_i  in  1  clock, all state updates on the rising edge
rst_i  in  1  synchronous, active-high reset
stall_i  in  1  hazard unit; hold the current output, no pop
pc_we_i  in  1  branch unit redirect strobe
pc_i  in  ADDR_W  redirect target
mem_req_o  out  1  fetch request valid
mem_addr_o  out  ADDR_W  fetch address
mem_gnt_i  in  1  request accepted this cycle (mem_req_o && mem_gnt_i)
mem_rvalid_i  in  1  response valid; responses return strictly in request order
mem_rdata_i  in  INST_W  response instruction
mem_err_i  in  1  response bus error, qualified by mem_rvalid_i
valid_o  out  1  inst_o / pc_o hold a real instruction
inst_o  out  INST_W  instruction to IF_ID
pc_o  out  ADDR_W  address of inst_o
anomaly_o  out  1  illegal encoding / misaligned / bus error flag for inst_o

Behaviour:
- Reset (rst_i high at an edge):
  - fetch_pc <= RESET_PC.
  - Queue empty.
  - outstanding = 0 and drop_cnt = 0.
  - Next cycle: valid_o = 0, mem_req_o = 0, inst_o = `INST_NOP (32'h00000013), pc_o = RESET_PC, anomaly_o = 0.
  - Reset mid-operation discards all state. The memory shares rst_i and must not answer pre-reset requests.
- Request issue:
  - mem_req_o = !rst_i && !pc_we_i && (outstanding < MAX_OUTSTANDING) && (count + outstanding - drop_cnt < DEPTH).
  - mem_addr_o = fetch_pc.
  - On grant: fetch_pc += 4 (wraps modulo 2^ADDR_W) and outstanding++.
  - Once raised, mem_req_o/mem_addr_o stay stable until granted, unless a redirect occurs.
- Response:
  - On mem_rvalid_i: outstanding--.
  - If drop_cnt > 0: drop_cnt-- and discard the data.
  - Otherwise push {pc, inst, flag} into the queue. pc comes from a parallel address queue of issued requests; flag = mem_err_i.
  - Grant and response in the same cycle: outstanding is unchanged.
- Output:
  - Driven from the queue head, registered storage, no combinational path from mem_rdata_i.
  - valid_o = !empty && !pc_we_i.
  - Pop when valid_o && !stall_i.
  - With a 1-cycle memory: grant at T, rvalid at T+1, valid_o at T+2.
  - Push and pop in the same cycle: count unchanged.
  - Overflow is impossible by the credit rule; a push while full is an assertion failure.
  - When empty: inst_o = `INST_NOP, anomaly_o = 0, pc_o = fetch_pc.
- anomaly_o = valid_o && (inst_o[1:0] != 2'b11 || pc_o[1:0] != 2'b00 || stored err flag).
- Redirect (pc_we_i high at an edge):
  - Queue flushed.
  - fetch_pc <= pc_i.
  - drop_cnt <= outstanding minus any response arriving that same cycle. That response is itself discarded.
  - No request in the redirect cycle; first request for pc_i in the next cycle.
  - Redirect overrides stall_i, pop and push.
  - Back-to-back redirects: the last one wins, and drop_cnt is recomputed each time.
  - A misaligned pc_i is fetched as given and flagged through anomaly_o.
- Stall with empty queue: no effect. Prefetch continues while stalled until credits run out.

Decomposition:
- Shared defines/package: `INST_WIDTH, `SYS_ADDR_SPACE, `On/`Off, `INST_NOP, RESET_PC default.
- Sub-module fetch_fifo: synchronous FIFO, parameters WIDTH and DEPTH; ports push, pop, flush, full, empty, head data; storage entry {pc, inst, err}.
- The outstanding-address queue reuses fetch_fifo with DEPTH = MAX_OUTSTANDING. It is flushed only by reset, not by redirect, because dropped responses still pop it.

Test Plan:
- Reset, 1-cycle memory returning 32'h00000013 at every address, stall_i = 0 -> valid_o first high 3 cycles after reset release; pc_o sequence 0, 4, 8, 12, one per cycle thereafter.
- stall_i held for 6 cycles after the first valid -> pc_o holds 0x0; mem_req_o drops once 4 entries are buffered; on release, pc_o = 4, 8, 12, 16 on consecutive cycles with no bubble.
- Memory latency 3 cycles, 2 requests outstanding, pc_we_i with pc_i = 0x100 -> both stale responses discarded; next valid_o shows pc_o = 0x100; no pre-redirect pc appears after the redirect.
- Response inst 32'h00004501 (16-bit encoding) at 0x8 -> anomaly_o = 1 only while pc_o = 0x8. Redirect to 0x102 -> anomaly_o = 1 at pc_o = 0x102.
- mem_err_i = 1 on the response for 0x20 -> inst_o = rdata and anomaly_o = 1 at pc_o = 0x20; neighbouring fetches clean.
- rst_i asserted mid-stream with 3 queued entries and 1 in flight -> next cycle valid_o = 0 and inst_o = 32'h00000013; fetching restarts at RESET_PC.
